// File: rtl/uart_tx_ctrl.sv
// UART TX frame sequencer: start, LSB-first data, optional parity, stop.
// Define UART_TX_TWO_STOP_EN to stretch the stop bit to two cycles.
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_Data,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_Bit,
  output logic                  Par_Load,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                r_state, w_next;
  logic [DATA_WIDTH-1:0] r_shift, w_shift;
  logic [CW-1:0]         r_cnt,   w_cnt;
  logic                  r_par,   w_par;
  logic                  r_par_en, w_par_en;
  logic                  r_tx,    w_tx;
  logic                  r_busy,  w_busy;
`ifdef UART_TX_TWO_STOP_EN
  logic                  r_stop_cnt, w_stop_cnt;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state  <= S_IDLE;
      r_shift  <= '0;
      r_cnt    <= '0;
      r_par    <= 1'b0;
      r_par_en <= 1'b0;
      r_tx     <= 1'b1;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_shift  <= w_shift;
      r_cnt    <= w_cnt;
      r_par    <= w_par;
      r_par_en <= w_par_en;
      r_tx     <= w_tx;
      r_busy   <= w_busy;
    end
  end

`ifdef UART_TX_TWO_STOP_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_stop_cnt <= 1'b0;
    else      r_stop_cnt <= w_stop_cnt;
  end
`endif

  // w_tx is the line value for the state being entered, so TX_OUT stays a
  // pure register output aligned with r_state.
  always_comb begin
    w_next   = r_state;
    w_shift  = r_shift;
    w_cnt    = r_cnt;
    w_par    = r_par;
    w_par_en = r_par_en;
    w_tx     = 1'b1;
    Par_Load = 1'b0;
`ifdef UART_TX_TWO_STOP_EN
    w_stop_cnt = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (Data_Valid) begin
          Par_Load = RST;
          w_next   = S_START;
          w_shift  = P_Data;
          w_par_en = PAR_EN;
          w_tx     = 1'b0;
        end
      end
      S_START: begin
        w_par  = PAR_Bit;
        w_next = S_DATA;
        w_cnt  = '0;
        w_tx   = r_shift[0];
      end
      S_DATA: begin
        w_shift = r_shift >> 1;
        if (r_cnt == LAST_BIT) begin
          if (r_par_en) begin
            w_next = S_PARITY;
            w_tx   = r_par;
          end else begin
            w_next = S_STOP;
          end
        end else begin
          w_cnt = r_cnt + 1'b1;
          w_tx  = r_shift[1];
        end
      end
      S_PARITY: w_next = S_STOP;
      S_STOP: begin
`ifdef UART_TX_TWO_STOP_EN
        if (!r_stop_cnt) w_stop_cnt = 1'b1;
        else             w_next     = S_IDLE;
`else
        w_next = S_IDLE;
`endif
      end
      default: w_next = S_IDLE;
    endcase
    w_busy = (w_next != S_IDLE);
  end

  assign TX_OUT = r_tx;
  assign Busy   = r_busy;

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Frame sequencer for the UART transmitter.
- Accepts a parallel word and drives the parity calculator's load strobe, then captures the returned parity bit.
- Serialises the frame onto the TX line, LSB first: start bit, DATA_WIDTH data bits, optional parity bit, stop bit.
- Sits between the host-side data interface and the TX pin; the parity calculator hangs off its Par_Load/PAR_Bit pair.

Parameters:
DATA_WIDTH, 8, width of the parallel data word and the number of data bits per frame (must be >= 2)

Ports:
CLK  input  1  bit-rate clock; one clock cycle = one bit period
RST  input  1  asynchronous reset, active-low
P_Data  input  DATA_WIDTH  parallel word to transmit; sampled on accept
Data_Valid  input  1  request to send P_Data; single-cycle or held
PAR_EN  input  1  1 = frame carries a parity bit; sampled on accept
PAR_Bit  input  1  parity result from the parity calculator; valid in the cycle after Par_Load
Par_Load  output  1  combinational; high in exactly the accept cycle; drives the parity calculator's Data_Valid
TX_OUT  output  1  serial line, registered, idle high
Busy  output  1  registered; high from the first START cycle through the last STOP cycle

Behaviour:
- Reset: state=IDLE, TX_OUT=1, Busy=0, bit counter=0, shift register=0, parity latch=0, PAR_EN latch=0. Par_Load=0 while RST is low.
- Reset asserted mid-frame aborts the frame immediately: TX_OUT returns to 1 asynchronously and no remaining bits are sent.
- Accept: Data_Valid=1 while state=IDLE.
  - Par_Load=1 in that cycle.
  - At that edge: P_Data goes into the shift register, PAR_EN into the latch, and state goes to START.
- Data_Valid in any non-IDLE state is ignored; Par_Load stays 0 and the word is not queued.
- States and required outputs:
  - IDLE: TX_OUT=1, Busy=0.
  - START: TX_OUT=0, Busy=1, one cycle. PAR_Bit is captured into the parity latch at the end of this cycle. Next state is DATA, counter=0.
  - DATA: TX_OUT=shift_reg[0]; shift right once per cycle; counter increments. When counter=DATA_WIDTH-1, next state is PARITY if the PAR_EN latch is 1, otherwise STOP.
  - PARITY: TX_OUT=parity latch, one cycle, then STOP.
  - STOP: TX_OUT=1, one cycle, then IDLE.
- Output timing:
  - TX_OUT and Busy are register outputs, updated on the same edge as the state. The first START bit appears on the edge after accept.
  - Frame length is 1+DATA_WIDTH+1+1 cycles with parity and 1+DATA_WIDTH+1 without.
  - Minimum one IDLE cycle between frames. Back-to-back throughput is one frame per frame length + 1 cycles.
- Counter is $clog2(DATA_WIDTH) bits and does not wrap within a frame; it is cleared on entry to DATA.
- Unused or illegal state encodings recover to IDLE with TX_OUT=1.
- No combinational path from P_Data to TX_OUT.

Optional Feature:
UART_TX_TWO_STOP_EN
- Defined: STOP lasts two cycles, tracked with a 1-bit stop counter, and TX_OUT=1 for both cycles. Frame length grows by 1.
- Undefined: single stop cycle; no stop counter logic present.

Test Plan:
- Even parity (PAR_EN=1, calculator PAR_Type=0), P_Data=8'hA5, one-cycle Data_Valid -> Par_Load high that cycle. TX_OUT from next edge: 0,1,0,1,0,0,1,0,1,0,1, then idle 1. Busy high for exactly 11 cycles.
- Odd parity (PAR_Type=1), P_Data=8'hA5 -> parity bit 1; otherwise identical to the even-parity frame.
- PAR_EN=0, P_Data=8'h0F -> TX_OUT 0,1,1,1,1,0,0,0,0,1. Busy high for 10 cycles; no parity slot.
- Data_Valid held high with 8'h3C then 8'hC3 -> first frame sent intact. Data_Valid during Busy is ignored: Par_Load stays 0 and the next accept occurs only in the first IDLE cycle after STOP.
- RST pulled low during data bit 3 -> TX_OUT=1 and Busy=0 immediately. After release with Data_Valid=0, the line stays 1 with no residual bits.
- With UART_TX_TWO_STOP_EN, 8'hA5 with even parity -> 12-cycle frame ending 1,1; Busy high for 12 cycles.
